// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with guard blanking and frame-aligned loads.
// Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits (digit 0 always shown).
module display_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [4*NDIG-1:0] load_data,
  input  logic [NDIG-1:0]   load_dp,
  output logic [6:0]        segments,
  output logic              dp,
  output logic [NDIG-1:0]   digit_en,
  output logic              frame_done
);
  localparam int MAXV = (DIV > GUARD) ? ((DIV > 2) ? DIV : 2) : ((GUARD > 2) ? GUARD : 2);
  localparam int CW   = $clog2(MAXV);
  localparam int IW   = $clog2(NDIG);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = (GUARD > 0) ? CW'(GUARD - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  typedef enum logic {ON, GRD} state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       idx_reg, idx_next, idx_inc;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                live_reg;
  logic [4*NDIG-1:0]   active_data_reg, active_data_next, pending_data_reg;
  logic [NDIG-1:0]     active_dp_reg, active_dp_next, pending_dp_reg;
  logic                pending_valid_reg;
  logic [6:0]          seg_reg, seg_next, dec_seg;
  logic                dp_reg, dp_next, fd_reg, fd_next;
  logic [NDIG-1:0]     en_reg, en_next, suppress;
  logic [3:0]          nib;
  logic                boundary, xfer;

  assign load_ready = ~pending_valid_reg;
  assign xfer       = load_valid && load_ready;
  assign boundary   = fd_reg && pending_valid_reg;
  assign idx_inc    = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

  // live_reg holds the first post-reset edge on ON/0/0 so slot 0 gets its full DIV cycles
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    if (live_reg) begin
      case (state_reg)
        ON: begin
          if (cnt_reg == DIV_LAST) begin
            cnt_next = '0;
            if (GUARD == 0) idx_next = idx_inc;
            else            state_next = GRD;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        GRD: begin
          if (cnt_reg == GRD_LAST) begin
            cnt_next   = '0;
            state_next = ON;
            idx_next   = idx_inc;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = ON;
      endcase
    end
  end

  always_comb begin
    active_data_next = boundary ? pending_data_reg : active_data_reg;
    active_dp_next   = boundary ? pending_dp_reg   : active_dp_reg;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG:1] hi_zero;
  assign hi_zero[NDIG] = 1'b1;
  assign suppress[0]   = 1'b0;
  generate
    for (genvar gi = 1; gi < NDIG; gi++) begin : g_blank
      assign hi_zero[gi]  = hi_zero[gi+1] && (active_data_next[4*gi +: 4] == 4'h0);
      assign suppress[gi] = hi_zero[gi] && !active_dp_next[gi];
    end
  endgenerate
`else
  assign suppress = '0;
`endif

  assign nib = active_data_next[idx_next*4 +: 4];

  hex_to_7seg u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  // Outputs are computed from the upcoming state so the registers line up with it
  always_comb begin
    en_next  = '1;
    seg_next = '0;
    dp_next  = 1'b0;
    if (state_next == ON && !suppress[idx_next]) begin
      en_next[idx_next] = 1'b0;
      seg_next          = dec_seg;
      dp_next           = active_dp_next[idx_next];
    end
    fd_next = (idx_next == IDX_LAST) &&
              ((GUARD == 0) ? (state_next == ON  && cnt_next == DIV_LAST)
                            : (state_next == GRD && cnt_next == GRD_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= ON;
      idx_reg           <= '0;
      cnt_reg           <= '0;
      live_reg          <= 1'b0;
      active_data_reg   <= '0;
      active_dp_reg     <= '0;
      pending_data_reg  <= '0;
      pending_dp_reg    <= '0;
      pending_valid_reg <= 1'b0;
      seg_reg           <= '0;
      dp_reg            <= 1'b0;
      en_reg            <= '1;
      fd_reg            <= 1'b0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      cnt_reg         <= cnt_next;
      live_reg        <= 1'b1;
      active_data_reg <= active_data_next;
      active_dp_reg   <= active_dp_next;
      seg_reg         <= seg_next;
      dp_reg          <= dp_next;
      en_reg          <= en_next;
      fd_reg          <= fd_next;
      // xfer needs pending empty, so it never collides with a boundary apply
      if (xfer) begin
        pending_data_reg  <= load_data;
        pending_dp_reg    <= load_dp;
        pending_valid_reg <= 1'b1;
      end else if (boundary) begin
        pending_valid_reg <= 1'b0;
      end
    end
  end

  assign segments   = seg_reg;
  assign dp         = dp_reg;
  assign digit_en   = en_reg;
  assign frame_done = fd_reg;
endmodule

// Hex nibble to abcdefg segment pattern, active-high, a = bit 6.
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      4'hF: seg = 7'h47;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl (NDIG=4, DIV=4, GUARD=2): vector table plus reset/boundary sequences.
module tb_display_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = DIV + GUARD;
  localparam int FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic        frame_done;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .segments   (segments),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [15:0]     data;
    logic [3:0]      dpv;
    logic [3:0][6:0] segs;   // expected pattern per digit, index = digit
    logic [3:0]      blank;  // digits suppressed when leading-zero blanking is built in
  } vec_t;

  int   checks = 0;
  int   passes = 0;
  int   pos;
  vec_t cur;
  vec_t zero_v;
  vec_t fd_v;
  vec_t rst_v;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (frame pos %0d)", name, act, exp, pos);
  endtask

  function automatic logic [3:0] eff_blank(input vec_t v);
`ifdef LEADING_ZERO_BLANK_EN
    return v.blank;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos == FRAME - 1) ? 0 : pos + 1;
  endtask

  task automatic check_cycle(input vec_t v);
    int slot, ph;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] bl;
    slot  = pos / SLOT;
    ph    = pos % SLOT;
    bl    = eff_blank(v);
    e_en  = 4'hF;
    e_seg = 7'h00;
    e_dp  = 1'b0;
    if (ph < DIV && !bl[slot]) begin
      e_en[slot] = 1'b0;
      e_seg      = v.segs[slot];
      e_dp       = v.dpv[slot];
    end
    check("display{en,seg,dp,fd}", {20'h0, digit_en, segments, dp, frame_done},
          {20'h0, e_en, e_seg, e_dp, (pos == FRAME - 1)});
  endtask

  task automatic run_to_end(input vec_t v, input logic exp_ready);
    do begin
      tick();
      check_cycle(v);
      check("load_ready", load_ready, exp_ready);
    end while (pos != FRAME - 1);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_en"}, digit_en, 4'hF);
    check({tag, "_seg"}, segments, 7'h00);
    check({tag, "_dp"}, dp, 1'b0);
    check({tag, "_fd"}, frame_done, 1'b0);
    check({tag, "_ready"}, load_ready, 1'b1);
  endtask

  initial begin
    zero_v  = '{data:16'h0000, dpv:4'b0000, segs:{7'h7E, 7'h7E, 7'h7E, 7'h7E}, blank:4'b1110};
    vecs[0] = '{data:16'h12AF, dpv:4'b0000, segs:{7'h30, 7'h6D, 7'h77, 7'h47}, blank:4'b0000};
    vecs[1] = '{data:16'h0005, dpv:4'b0000, segs:{7'h7E, 7'h7E, 7'h7E, 7'h5B}, blank:4'b1110};
    vecs[2] = '{data:16'h3C81, dpv:4'b0101, segs:{7'h79, 7'h4E, 7'h7F, 7'h30}, blank:4'b0000};
    vecs[3] = '{data:16'h0040, dpv:4'b0100, segs:{7'h7E, 7'h7E, 7'h33, 7'h7E}, blank:4'b1000};
    fd_v    = '{data:16'h9E06, dpv:4'b1000, segs:{7'h7B, 7'h4F, 7'h7E, 7'h5F}, blank:4'b0000};
    rst_v   = '{data:16'h1111, dpv:4'b0000, segs:{7'h30, 7'h30, 7'h30, 7'h30}, blank:4'b0000};

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    load_dp    = 4'h0;
    pos        = 0;

    // Reset held for 3 cycles, then a full frame of zeros
    repeat (3) begin
      @(posedge clk);
      #1;
      check_dark("reset");
    end
    rst_n = 1'b1;
    pos   = FRAME - 1;
    cur   = zero_v;
    run_to_end(cur, 1'b1);
    $display("reset release: frame of %h shown", cur.data);

    // Load at cycle 5, blocked second load until boundary, new value next frame
    for (int i = 0; i < 4; i++) begin
      while (pos != 5) begin
        tick();
        check_cycle(cur);
      end
      check("ready_before_load", load_ready, 1'b1);
      load_valid = 1'b1;
      load_data  = vecs[i].data;
      load_dp    = vecs[i].dpv;
      tick();
      check_cycle(cur);
      check("ready_after_load", load_ready, 1'b0);
      load_data = ~vecs[i].data;
      load_dp   = ~vecs[i].dpv;
      while (pos != FRAME - 1) begin
        tick();
        check_cycle(cur);
        check("ready_pending", load_ready, 1'b0);
      end
      tick();
      check_cycle(vecs[i]);
      check("ready_after_boundary", load_ready, 1'b1);
      load_valid = 1'b0;
      cur = vecs[i];
      run_to_end(cur, 1'b1);
      $display("load %h dp %b at pos 5: applied next frame", vecs[i].data, vecs[i].dpv);
    end

    // Load on the frame_done cycle: applied one boundary later
    check("fd_cycle", frame_done, 1'b1);
    check("ready_on_fd", load_ready, 1'b1);
    load_valid = 1'b1;
    load_data  = fd_v.data;
    load_dp    = fd_v.dpv;
    tick();
    load_valid = 1'b0;
    check_cycle(cur);
    check("ready_fd_pending", load_ready, 1'b0);
    run_to_end(cur, 1'b0);
    tick();
    check_cycle(fd_v);
    check("ready_fd_applied", load_ready, 1'b1);
    cur = fd_v;
    run_to_end(cur, 1'b1);
    $display("load %h on frame_done cycle: applied after one extra frame", fd_v.data);

    // Reset mid-slot with a load pending
    while (pos != 5) begin
      tick();
      check_cycle(cur);
    end
    load_valid = 1'b1;
    load_data  = rst_v.data;
    load_dp    = rst_v.dpv;
    tick();
    load_valid = 1'b0;
    check("ready_rst_pending", load_ready, 1'b0);
    while (pos != 8) begin
      tick();
      check_cycle(cur);
    end
    rst_n = 1'b0;
    #1;
    check_dark("async_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_dark("reset_hold");
    end
    rst_n = 1'b1;
    pos   = FRAME - 1;
    cur   = zero_v;
    run_to_end(cur, 1'b1);
    run_to_end(cur, 1'b1);
    $display("reset mid-slot with %h pending: display returns to zero, pending dropped", rst_v.data);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
